// File: rtl/twos_to_signmag_serial.sv
// Bit-serial two's-complement to sign-magnitude decoder, LSB first, one bit per clock.
// Start-to-done is W+1 cycles and one word per W+2 cycles; start is ignored while busy.
module twos_to_signmag_serial #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] din,
  output logic         busy,
  output logic         done,
  output logic         sign,
  output logic [W-1:0] mag
);

  localparam int             CW   = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t         r_state;
  logic [W-1:0]   r_sh;
  logic           r_sgn;
  logic           r_seen;
  logic [CW-1:0]  r_cnt;
  logic           r_busy;
  logic           r_done;
  logic           r_sign;
  logic [W-1:0]   r_mag;

  logic           w_b;
  logic           w_ob;
  logic [W-1:0]   w_next;

  // Operand bits leave at the bottom while result bits enter at the top, so one
  // register serves as both shifter and result; after W shifts it holds |din|.
  assign w_b    = r_sh[0];
  assign w_ob   = (r_sgn && r_seen) ? ~w_b : w_b;
  assign w_next = {w_ob, r_sh[W-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_sh    <= '0;
      r_sgn   <= 1'b0;
      r_seen  <= 1'b0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sign  <= 1'b0;
      r_mag   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sh    <= din;
            r_sgn   <= din[W-1];
            r_seen  <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_sh   <= w_next;
          r_seen <= r_seen | w_b;
          r_cnt  <= r_cnt + CW'(1);
          if (r_cnt == LAST) begin
            r_mag   <= w_next;
            r_sign  <= r_sgn;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sign = r_sign;
  assign mag  = r_mag;

endmodule

// File: tb/tb_twos_to_signmag_serial.sv
// Directed bench for twos_to_signmag_serial (W=8): latency, busy window, boundaries,
// ignored restart, mid-conversion reset and a back-to-back sweep over -63..64.
module tb_twos_to_signmag_serial;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] din;
  logic       busy;
  logic       done;
  logic       sign;
  logic [7:0] mag;

  int checks;
  int errors;

  twos_to_signmag_serial #(.W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .din   (din),
    .busy  (busy),
    .done  (done),
    .sign  (sign),
    .mag   (mag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called #1 after a rising edge with the DUT idle; returns #1 after the edge
  // that takes it back to idle, so a following call starts back-to-back.
  task automatic convert(input logic [7:0] d, input logic exp_sign,
                         input logic [7:0] exp_mag, input string tag);
    int lat;
    int bcnt;
    bit got;
    start = 1'b1;
    din   = d;
    @(posedge clk); #1;
    start = 1'b0;
    din   = 8'($urandom);
    lat   = 1;
    bcnt  = 0;
    got   = 1'b0;
    while (lat < 20) begin
      if (busy) bcnt++;
      if (done) begin
        got = 1'b1;
        break;
      end
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_done_seen"}, 32'(got), 32'd1);
    check({tag, "_latency"}, lat, 9);
    check({tag, "_busy_cycles"}, bcnt, 9);
    check({tag, "_sign"}, 32'(sign), 32'(exp_sign));
    check({tag, "_mag"}, 32'(mag), 32'(exp_mag));
    @(posedge clk); #1;
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
    check({tag, "_done_after"}, 32'(done), 32'd0);
  endtask

  initial begin
    int k;
    int dones;
    int dlat;
    logic [7:0] d;
    logic [7:0] em;

    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    din    = 8'h00;

    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_sign", 32'(sign), 32'd0);
    check("reset_mag", 32'(mag), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    convert(8'hFB, 1'b1, 8'h05, "neg5");
    convert(8'h7F, 1'b0, 8'h7F, "pos127");
    convert(8'h00, 1'b0, 8'h00, "zero");
    convert(8'h80, 1'b1, 8'h80, "most_neg");
    convert(8'hFF, 1'b1, 8'h01, "minus1");

    // Second start pulse mid-conversion must be ignored.
    start = 1'b1;
    din   = 8'hC1;
    @(posedge clk); #1;
    start = 1'b0;
    dones = 0;
    dlat  = 0;
    for (k = 1; k <= 14; k++) begin
      if (k == 3) begin
        start = 1'b1;
        din   = 8'h12;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        dones++;
        if (dlat == 0) dlat = k;
      end
      @(posedge clk); #1;
    end
    check("restart_done_count", dones, 1);
    check("restart_latency", dlat, 9);
    check("restart_sign", 32'(sign), 32'd1);
    check("restart_mag", 32'(mag), 32'h3F);

    // Reset during SHIFT aborts and clears the held result.
    start = 1'b1;
    din   = 8'hF0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_sign", 32'(sign), 32'd0);
    check("midrst_mag", 32'(mag), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    dones = 0;
    for (k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    check("midrst_no_done", dones, 0);
    convert(8'h05, 1'b0, 8'h05, "after_rst");

    // Back-to-back sweep against the arithmetic model.
    for (int v = -63; v <= 64; v++) begin
      d  = v[7:0];
      em = d[7] ? (~d + 8'd1) : d;
      convert(d, d[7], em, "sweep");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
